// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared frame constants, arbiter state type and saturating increment
package i2s_pkg;

  localparam int FRAME_W = 64;
  localparam int L_MSB   = 63;
  localparam int L_LSB   = 32;
  localparam int R_MSB   = 31;
  localparam int R_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  // Counters up to 32 bits wide share this; the value sticks at all-ones of width w.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searches upward from i_ptr+1 with wrap
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int w_j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/i2s_dac_frame_arbiter.sv
// rtl/i2s_dac_frame_arbiter.sv - shares one stereo DAC stream between N_SRC sources, one frame per lrck period
module i2s_dac_frame_arbiter
  import i2s_pkg::*;
#(
  parameter int N_SRC               = 4,
  parameter int FRAME_CYCLES_LOG2   = 9,
  parameter bit SILENCE_ON_UNDERRUN = 1'b1,
  parameter int CNT_W               = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [64*N_SRC-1:0]        src_tdata,
  input  logic [N_SRC-1:0]           src_tvalid,
  output logic [N_SRC-1:0]           src_tready,
  input  logic [N_SRC-1:0]           src_en,
  output logic [FRAME_W-1:0]         dac_tdata,
  output logic                       dac_tvalid,
  input  logic                       dac_tready,
  output logic [$clog2(N_SRC)-1:0]   grant_idx,
  output logic                       grant_valid,
  output logic                       frame_tick,
  output logic [CNT_W-1:0]           underrun_cnt,
  output logic [CNT_W-1:0]           overrun_cnt
);

  localparam int IW = $clog2(N_SRC);

  logic [FRAME_CYCLES_LOG2-1:0] r_frame_cnt;
  arb_state_t                   r_state;
  logic [IW-1:0]                r_ptr;
  logic [IW-1:0]                r_grant_idx;
  logic                         r_grant_valid;
  logic [FRAME_W-1:0]           r_data;
  logic [CNT_W-1:0]             r_underrun;
  logic [CNT_W-1:0]             r_overrun;

  logic [N_SRC-1:0]             w_req;
  logic [N_SRC-1:0]             w_grant;
  logic [IW-1:0]                w_win_idx;
  logic                         w_win_any;
  logic                         w_tick;
  logic                         w_in_arb;

  assign w_tick   = &r_frame_cnt;
  assign w_req    = src_tvalid & src_en;
  assign w_in_arb = (r_state == ARB);

  rr_arbiter #(
    .N  (N_SRC),
    .IW (IW)
  ) u_rr (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_win_any)
  );

  // The ack is only ever offered during the single ARB cycle.
  assign src_tready   = w_in_arb ? w_grant : '0;
  assign dac_tvalid   = (r_state == XFER);
  assign dac_tdata    = r_data;
  assign grant_idx    = r_grant_idx;
  assign grant_valid  = r_grant_valid;
  assign frame_tick   = w_tick;
  assign underrun_cnt = r_underrun;
  assign overrun_cnt  = r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_state       <= IDLE;
      r_ptr         <= IW'(N_SRC - 1);
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
      r_data        <= '0;
      r_underrun    <= '0;
      r_overrun     <= '0;
    end else begin
      r_frame_cnt   <= r_frame_cnt + FRAME_CYCLES_LOG2'(1);
      r_grant_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) r_state <= ARB;
        end
        ARB: begin
          if (w_win_any) begin
            r_data        <= src_tdata[w_win_idx*FRAME_W +: FRAME_W];
            r_ptr         <= w_win_idx;
            r_grant_idx   <= w_win_idx;
            r_grant_valid <= 1'b1;
            r_state       <= XFER;
          end else begin
            r_underrun <= CNT_W'(sat_inc(32'(r_underrun), CNT_W));
            if (SILENCE_ON_UNDERRUN) begin
              r_data  <= '0;
              r_state <= XFER;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        XFER: begin
          // A tick coinciding with the handshake is honoured; otherwise it is dropped.
          if (dac_tready) begin
            r_state <= w_tick ? ARB : IDLE;
          end else if (w_tick) begin
            r_overrun <= CNT_W'(sat_inc(32'(r_overrun), CNT_W));
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_dac_frame_arbiter.sv
// tb/tb_i2s_dac_frame_arbiter.sv - directed self-checking bench for i2s_dac_frame_arbiter
module tb_i2s_dac_frame_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [64*N-1:0] src_tdata;
  logic [N-1:0]   src_tvalid = '0;
  logic [N-1:0]   src_tready;
  logic [N-1:0]   src_en = '0;
  logic [63:0]    dac_tdata;
  logic           dac_tvalid;
  logic           dac_tready = 1'b0;
  logic [1:0]     grant_idx;
  logic           grant_valid;
  logic           frame_tick;
  logic [15:0]    underrun_cnt;
  logic [15:0]    overrun_cnt;

  i2s_dac_frame_arbiter #(
    .N_SRC               (N),
    .FRAME_CYCLES_LOG2   (9),
    .SILENCE_ON_UNDERRUN (1'b1),
    .CNT_W               (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_tdata    (src_tdata),
    .src_tvalid   (src_tvalid),
    .src_tready   (src_tready),
    .src_en       (src_en),
    .dac_tdata    (dac_tdata),
    .dac_tvalid   (dac_tvalid),
    .dac_tready   (dac_tready),
    .grant_idx    (grant_idx),
    .grant_valid  (grant_valid),
    .frame_tick   (frame_tick),
    .underrun_cnt (underrun_cnt),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] frames[$];
  int          frame_cyc[$];
  int          hs_delta[$];
  logic [1:0]  grants[$];
  logic [N-1:0] tready_seen = '0;
  int          tready_delta = -1;
  int          multi_hot = 0;
  int          unstable = 0;
  int          last_tick = 0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [63:0] prev_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_tick) last_tick = cyc;
      if (src_tready != '0) begin
        tready_seen = tready_seen | src_tready;
        tready_delta = cyc - last_tick;
        if (!$onehot(src_tready)) multi_hot++;
      end
      if (grant_valid) grants.push_back(grant_idx);
      if (dac_tvalid && dac_tready) begin
        frames.push_back(dac_tdata);
        frame_cyc.push_back(cyc);
        hs_delta.push_back(cyc - last_tick);
      end
      if (dac_tvalid && prev_valid && !prev_hs && dac_tdata != prev_data) unstable++;
      prev_valid = dac_tvalid;
      prev_hs    = dac_tvalid && dac_tready;
      prev_data  = dac_tdata;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    frames.delete();
    frame_cyc.delete();
    hs_delta.delete();
    grants.delete();
    tready_seen  = '0;
    tready_delta = -1;
    multi_hot    = 0;
    unstable     = 0;
    prev_valid   = 1'b0;
    prev_hs      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick_n(3);
    clear_obs();
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    int k = 0;
    while (frames.size() < n && k < budget) begin
      tick_n(1);
      k++;
    end
    check_eq({tag, "_frames_timeout"}, 64'(frames.size() >= n), 64'd1);
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k = 0;
    while (grants.size() < n && k < budget) begin
      tick_n(1);
      k++;
    end
    check_eq({tag, "_grants_timeout"}, 64'(grants.size() >= n), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) src_tdata[64*i +: 64] = 64'hA0 + 64'(i);

    // reset state
    rst = 1'b1;
    tick_n(3);
    check_eq("rst_dac_tvalid", 64'(dac_tvalid), 64'd0);
    check_eq("rst_dac_tdata", dac_tdata, 64'd0);
    check_eq("rst_src_tready", 64'(src_tready), 64'd0);
    check_eq("rst_grant", 64'({grant_valid, grant_idx}), 64'd0);
    check_eq("rst_frame_tick", 64'(frame_tick), 64'd0);
    check_eq("rst_counters", 64'({underrun_cnt, overrun_cnt}), 64'd0);
    clear_obs();
    rst = 1'b0;

    // all sources, round robin over 8 frames
    src_tvalid = 4'hF;
    src_en     = 4'hF;
    dac_tready = 1'b1;
    wait_frames(8, 8*512 + 700, "rr_all");
    if (frames.size() >= 8) begin
      for (int i = 0; i < 8; i++) check_eq($sformatf("rr_all_data%0d", i), frames[i], 64'hA0 + 64'(i % 4));
      for (int i = 0; i < 7; i++) check_eq($sformatf("rr_all_period%0d", i), 64'(frame_cyc[i+1] - frame_cyc[i]), 64'd512);
      check_eq("lat_tick_to_dac", 64'(hs_delta[0]), 64'd2);
    end
    check_eq("lat_tick_to_tready", 64'(tready_delta), 64'd1);
    check_eq("rr_all_underrun", 64'(underrun_cnt), 64'd0);
    check_eq("rr_all_onehot", 64'(multi_hot), 64'd0);

    // enable mask 1010
    do_reset();
    src_en = 4'b1010;
    wait_grants(4, 4*512 + 700, "mask");
    if (grants.size() >= 4) begin
      check_eq("mask_g0", 64'(grants[0]), 64'd1);
      check_eq("mask_g1", 64'(grants[1]), 64'd3);
      check_eq("mask_g2", 64'(grants[2]), 64'd1);
      check_eq("mask_g3", 64'(grants[3]), 64'd3);
    end
    if (frames.size() >= 1) check_eq("mask_data0", frames[0], 64'hA1);
    check_eq("mask_tready_0_2", 64'(tready_seen & 4'b0101), 64'd0);

    // underrun silence then pointer preserved
    do_reset();
    src_tvalid = 4'h0;
    src_en     = 4'hF;
    wait_frames(3, 3*512 + 700, "silence");
    if (frames.size() >= 3)
      for (int i = 0; i < 3; i++) check_eq($sformatf("silence_data%0d", i), frames[i], 64'd0);
    check_eq("silence_underrun", 64'(underrun_cnt), 64'd3);
    check_eq("silence_no_grant", 64'(grants.size()), 64'd0);
    src_tvalid = 4'hF;
    wait_grants(1, 700, "after_silence");
    if (grants.size() >= 1) check_eq("after_silence_grant", 64'(grants[0]), 64'd0);
    check_eq("after_silence_underrun", 64'(underrun_cnt), 64'd3);

    // overrun while DAC stalls
    do_reset();
    src_tvalid = 4'hF;
    dac_tready = 1'b0;
    wait_grants(1, 700, "overrun");
    tick_n(1100);
    check_eq("overrun_cnt", 64'(overrun_cnt), 64'd2);
    check_eq("overrun_held_valid", 64'(dac_tvalid), 64'd1);
    check_eq("overrun_held_data", dac_tdata, 64'hA0);
    check_eq("overrun_stable", 64'(unstable), 64'd0);
    check_eq("overrun_no_frame", 64'(frames.size()), 64'd0);
    dac_tready = 1'b1;
    wait_frames(1, 10, "overrun_release");
    if (frames.size() >= 1) check_eq("overrun_delivered", frames[0], 64'hA0);
    check_eq("overrun_cnt_after", 64'(overrun_cnt), 64'd2);

    // reset mid-transfer
    do_reset();
    dac_tready = 1'b1;
    wait_frames(1, 700, "midrst_first");
    dac_tready = 1'b0;
    wait_grants(2, 700, "midrst_second");
    if (grants.size() >= 2) check_eq("midrst_pre_grant", 64'(grants[1]), 64'd1);
    check_eq("midrst_in_xfer", 64'(dac_tvalid), 64'd1);
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
    check_eq("midrst_tvalid", 64'(dac_tvalid), 64'd0);
    check_eq("midrst_grant_idx", 64'(grant_idx), 64'd0);
    check_eq("midrst_counters", 64'({underrun_cnt, overrun_cnt}), 64'd0);
    clear_obs();
    tick_n(5);
    check_eq("midrst_idle", 64'(dac_tvalid), 64'd0);
    dac_tready = 1'b1;
    wait_grants(1, 700, "midrst_after");
    if (grants.size() >= 1) check_eq("midrst_ptr_reset", 64'(grants[0]), 64'd0);

    // source withdraws valid on the tick cycle
    do_reset();
    src_tvalid = 4'b0100;
    begin
      int k = 0;
      while (!frame_tick && k < 700) begin
        tick_n(1);
        k++;
      end
      check_eq("withdraw_tick_timeout", 64'(frame_tick), 64'd1);
    end
    src_tvalid = 4'b0000;
    tick_n(5);
    check_eq("withdraw_underrun", 64'(underrun_cnt), 64'd1);
    check_eq("withdraw_no_ack", 64'(tready_seen), 64'd0);
    check_eq("withdraw_no_grant", 64'(grants.size()), 64'd0);
    check_eq("withdraw_silence_frames", 64'(frames.size()), 64'd1);
    if (frames.size() >= 1) check_eq("withdraw_silence_data", frames[0], 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_dac_frame_arbiter.md
Name: i2s_dac_frame_arbiter

Overview:
- Shares the single 64-bit stereo DAC stream (left in [63:32], right in [31:0]) of the I2S pmod block between N_SRC requesters.
- Issues at most one frame per audio frame period (FRAME_CYCLES clocks, equal to one lrck period).
- Grants requesters round-robin, masked by a per-source enable.
- Inserts silence when no enabled source has data. Counts underruns and overruns for debug.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- FRAME_CYCLES_LOG2, 9, frame period = 2**FRAME_CYCLES_LOG2 clocks; must match the I2S divider factor.
- SILENCE_ON_UNDERRUN, 1, 1: send 64'h0 on underrun; 0: send nothing that frame.
- CNT_W, 16, width of the underrun/overrun counters.

Ports:
- clk  in  1  system clock (same as I2S mclk domain)
- rst  in  1  synchronous, active-high reset
- src_tdata  in  64*N_SRC  source i frame at [64*i+63 : 64*i]
- src_tvalid  in  N_SRC  per-source valid
- src_tready  out  N_SRC  per-source ready
- src_en  in  N_SRC  per-source enable mask
- dac_tdata  out  64  frame to the I2S DAC stream input
- dac_tvalid  out  1  frame valid
- dac_tready  in  1  DAC stream ready
- grant_idx  out  $clog2(N_SRC)  index of the last granted source
- grant_valid  out  1  pulse: grant_idx updated this cycle
- frame_tick  out  1  one-cycle pulse at frame boundary
- underrun_cnt  out  CNT_W  frames with no eligible source, saturating
- overrun_cnt  out  CNT_W  frame ticks missed while a transfer was pending, saturating

Behaviour:
- Reset: all outputs 0. Frame counter 0, FSM IDLE, RR pointer = N_SRC-1 (so source 0 has first priority), counters 0, data register 0.
- Frame counter: free-running FRAME_CYCLES_LOG2 bits, wraps. frame_tick=1 when counter is all-ones.
- States: IDLE, ARB, XFER.
- IDLE: on frame_tick go to ARB.
- ARB (exactly one cycle):
  - eligible = src_valid & src_en. src_en is sampled only here; changes at other times are ignored until the next ARB.
  - Winner = first eligible index searching upward from pointer+1, wrapping.
  - If a winner exists: src_tready[winner]=1 (combinational, this cycle only), capture its data, pointer <= winner, grant_idx <= winner, grant_valid=1 next cycle, then XFER.
  - If no winner: underrun_cnt += 1 (saturating at all-ones); pointer unchanged.
    - SILENCE_ON_UNDERRUN=1: capture 64'h0, go to XFER.
    - SILENCE_ON_UNDERRUN=0: go to IDLE.
- XFER: dac_tvalid=1 and dac_tdata held stable until dac_tvalid & dac_tready, then IDLE.
  - A frame_tick while in XFER: overrun_cnt += 1 (saturating); the tick is dropped and the held frame is still delivered.
  - frame_tick on the same cycle as the handshake: handshake completes, go to ARB directly, no overrun.
- src_tready is never asserted outside ARB, and at most one bit is set at a time.
- Latency: frame_tick at cycle T → src_tready at T+1 → dac_tvalid at T+2. Best case one frame per period.
- No source is starved: with k eligible sources, each is granted within k frames.
- Reset mid-XFER: dac_tvalid drops on the next edge; the pending frame is discarded; no counters change.

Decomposition:
- Shared package i2s_pkg:
  - FRAME_W=64, L/R slice constants.
  - arb_state_t enum {IDLE, ARB, XFER}.
  - Saturating-increment function.
- Sub-module rr_arbiter (N-wide).
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any-grant flag.
  - Purely combinational; reused by future ADC-side fan-out.
- Top holds the counter, FSM, data register and counters.

Test Plan:
- All 4 sources valid with data 64'hA0..A3 and src_en=4'hF, dac_tready=1, for 8 frames → DAC sees A0,A1,A2,A3,A0,A1,A2,A3; one per 512 clocks; underrun_cnt=0.
- src_en=4'b1010, all valid → grants alternate 1,3,1,3; src_tready[0] and src_tready[2] never asserted.
- No sources valid for 3 frames, SILENCE_ON_UNDERRUN=1 → three 64'h0 frames on the DAC; underrun_cnt=3; pointer unchanged, so the next valid source 0 is granted first.
- dac_tready held 0 for 1100 clocks after a grant → overrun_cnt=2; dac_tdata stable throughout; frame delivered when ready rises.
- rst asserted one cycle in XFER → next cycle dac_tvalid=0, FSM IDLE, pointer=N_SRC-1, counters unchanged at 0 if they were 0.
- Source 2 alone valid and deasserts tvalid the cycle before ARB → underrun counted; source 2 not acked.
